// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: binarises a serial grayscale pixel stream against THRESHOLD and
// assembles HEIGHT x LENGTH binary frames, row-major, into a double-buffered output word.
// The fill buffer collects the next frame while the image register holds the current one.
// Optional feature, enabled by defining PIXEL_FRAME_SOF_EN: adds a pix_sof input that
// restarts the frame at (0,0) and a sticky sof_err output for out-of-place SOF markers.
module pixel_frame_loader #(
  parameter int unsigned HEIGHT    = 28,
  parameter int unsigned LENGTH    = 28,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [PIX_W-1:0]               pix_data,
`ifdef PIXEL_FRAME_SOF_EN
  input  logic                           pix_sof,
  output logic                           sof_err,
`endif
  output logic [HEIGHT-1:0][LENGTH-1:0]  image,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [15:0]                    frame_count
);

  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned ColW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(LENGTH - 1);

  typedef enum logic [0:0] {
    StFill,
    StWait
  } state_e;

  state_e                          state_q, state_d;
  logic [RowW-1:0]                 row_q, row_d;
  logic [ColW-1:0]                 col_q, col_d;
  logic [HEIGHT-1:0][LENGTH-1:0]   fill_q, fill_d;
  logic [HEIGHT-1:0][LENGTH-1:0]   image_q, image_d;
  logic                            frame_valid_q, frame_valid_d;
  logic [15:0]                     frame_count_q, frame_count_d;

  logic                            pix_accept;
  logic                            pix_bit;
  logic                            sof_restart;
  logic [RowW-1:0]                 cur_row;
  logic [ColW-1:0]                 cur_col;
  logic                            at_last;
  logic                            slot_free;
  logic                            load_fill;
  logic                            release_wait;
  logic                            transfer;

  // Handshake qualification, binarisation and the effective write position.
  always_comb begin
    pix_accept = pix_valid && (state_q == StFill);
    pix_bit    = (32'(pix_data) >= THRESHOLD);
`ifdef PIXEL_FRAME_SOF_EN
    // SOF at the origin is an ordinary pixel; anywhere else it restarts the frame.
    sof_restart = pix_accept && pix_sof && ((row_q != '0) || (col_q != '0));
`else
    sof_restart = 1'b0;
`endif
    cur_row   = sof_restart ? '0 : row_q;
    cur_col   = sof_restart ? '0 : col_q;
    at_last   = (cur_row == RowLast) && (cur_col == ColLast);
    slot_free = !frame_valid_q || frame_ready;
  end

  // Decide when the fill buffer moves into the image register.
  always_comb begin
    load_fill    = pix_accept && at_last && slot_free;
    release_wait = (state_q == StWait) && frame_ready;
    transfer     = load_fill || release_wait;
  end

  // Fill buffer next state: write one bit per accepted pixel; frozen otherwise.
  always_comb begin
    fill_d = fill_q;
    if (pix_accept) begin
      if (sof_restart) begin
        fill_d = '0;
      end
      fill_d[cur_row][cur_col] = pix_bit;
    end
  end

  // Row-major position counter, wrapping to (0,0) after the last pixel.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (pix_accept) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
    end
  end

  // FSM: park in StWait when a frame completes but the output slot is still occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFill: begin
        if (pix_accept && at_last && !slot_free) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (frame_ready) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Output slot: a transfer beats a simultaneous consume; consume alone keeps image.
  always_comb begin
    image_d       = image_q;
    frame_valid_d = frame_valid_q;
    frame_count_d = frame_count_q;
    if (transfer) begin
      image_d       = fill_d;
      frame_valid_d = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFill;
      row_q         <= '0;
      col_q         <= '0;
      fill_q        <= '0;
      image_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      fill_q        <= fill_d;
      image_q       <= image_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef PIXEL_FRAME_SOF_EN
  logic sof_err_q;

  // Sticky flag for an SOF marker seen away from the origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_err_q <= 1'b0;
    end else if (sof_restart) begin
      sof_err_q <= 1'b1;
    end
  end

  assign sof_err = sof_err_q;
`endif

  assign pix_ready   = (state_q == StFill);
  assign image       = image_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Upstream stage of the pixel-summing block.
- Accepts a serial stream of grayscale pixels over a valid/ready handshake and binarises each pixel against a threshold.
- Assembles the bits row-major into a HEIGHT x LENGTH binary image and presents each completed frame as a packed word with a valid/ready handshake.
- Double-buffered: filling the next frame overlaps with holding the current one.

Parameters:
- HEIGHT, 28, image rows (matches global_params.vh).
- LENGTH, 28, image columns (matches global_params.vh).
- PIX_W, 8, input pixel width in bits.
- THRESHOLD, 128, binarisation level; bit = 1 iff pix_data >= THRESHOLD (unsigned compare).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  loader accepts a pixel this cycle.
- pix_data  input  PIX_W  unsigned grayscale pixel.
- image  output  [HEIGHT-1:0][LENGTH-1:0]  completed binary frame; image[r][c] = row r, column c.
- frame_valid  output  1  image holds an unconsumed frame.
- frame_ready  input  1  consumer takes the frame.
- frame_count  output  16  number of frames transferred to image; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, active-high):
  - state = FILL; row = col = 0; fill buffer = 0.
  - image = 0; frame_valid = 0; frame_count = 0; pix_ready = 1 after reset deasserts.
  - Reset mid-frame discards the partial frame and any held frame.
- Handshakes:
  - Pixel accept: pix_valid && pix_ready at a rising edge.
  - Frame consume: frame_valid && frame_ready at a rising edge.
- pix_ready = (state == FILL). It is purely registered state, with no combinational path from any input.
- Pixel accept in FILL:
  - fill[row][col] <= (pix_data >= THRESHOLD).
  - col increments. At col == LENGTH-1, col wraps to 0 and row increments.
  - At row == HEIGHT-1 and col == LENGTH-1 (last pixel), row and col both return to 0.
- Last pixel accepted at edge N, with the output slot free in that cycle (frame_valid == 0, or frame_ready == 1):
  - image <= fill buffer including the last bit.
  - frame_valid = 1 from N+1; frame_count increments; state stays FILL.
  - The next pixel may be accepted at edge N+1 (zero bubbles).
- Last pixel accepted with the slot occupied and frame_ready == 0:
  - state <= WAIT; pix_ready = 0 from N+1.
- WAIT:
  - Fill buffer is frozen.
  - At the first edge where frame_ready == 1, image <= fill buffer; frame_valid stays 1; frame_count increments; state <= FILL.
  - pix_ready returns to 1 the following cycle.
- Frame consumed with no transfer at the same edge: frame_valid <= 0; image retains its value (not cleared).
- Simultaneous consume and transfer at the same edge: the transfer wins, and frame_valid stays 1 with the new image.
- image is stable whenever frame_valid == 1 and frame_ready == 0.
- pix_valid low stalls the fill indefinitely. Counters and buffer hold.
- The fill buffer is not cleared between frames. Every bit is overwritten before the next transfer.
- Latency: last pixel accept to frame_valid/image update = 1 cycle when the slot is free.

Optional Feature:
- Macro: PIXEL_FRAME_SOF_EN.
- Defined:
  - Adds input pix_sof (1 bit, qualified by the pixel accept).
  - An accepted pixel with pix_sof = 1 is written at (0,0), and the fill buffer's other bits are cleared at the same edge. row/col continue from (0,1).
  - The partial frame is discarded with no transfer.
  - Adds output sof_err (1 bit, sticky until reset): set when pix_sof arrives at any position other than (0,0).
  - pix_sof at (0,0) behaves as a normal pixel.
- Undefined: no pix_sof or sof_err ports; position is determined only by counting accepted pixels.

Test Plan (HEIGHT = LENGTH = 4, THRESHOLD = 128):
- Reset, then stream 16 pixels alternating 200/50 with frame_ready = 1 -> frame_valid rises 1 cycle after the 16th accept; image rows = 4'b0101 each; frame_count = 1.
- Pixel 127 then 128 at positions 0 and 1 -> image[0][0] = 0, image[0][1] = 1 (threshold boundary).
- Hold frame_ready = 0 and stream 32 pixels continuously -> first frame held unchanged; pix_ready drops 1 cycle after the 32nd accept; raising frame_ready for one cycle loads frame 2; pix_ready = 1 the next cycle; frame_count = 2.
- Back-to-back frames with frame_valid && frame_ready at the transfer edge -> frame_valid stays 1, image switches to frame 2, no pixel bubble.
- Assert rst after 7 pixels, then stream 16 pixels of 255 -> image = all ones; frame_count = 1; none of the 7 pre-reset pixels appear.
- PIXEL_FRAME_SOF_EN: send 5 pixels, then pix_sof = 1 with pix_data = 255, then 15 pixels of 0 -> exactly one frame with only image[0][0] = 1; sof_err = 1.
